data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_load_align.sv | 36 +++
 rtl/data_mem_pipe.sv | 140 ++++++++++++++
 tb/tb_data_mem_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory pipe: access sizes, controller states
// and the byte-lane helpers used by both the store and the load paths.
package dmem_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

  // Byte lanes touched by an access of the given size, before shifting to its offset.
  function automatic logic [7:0] size_lanes(input mem_size_e sz);
    case (sz)
      SZ_BYTE: return 8'h01;
      SZ_HALF: return 8'h03;
      SZ_WORD: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_mask(input mem_size_e sz);
    return 3'((4'd1 << sz) - 4'd1);
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load path: shifts the addressed lanes down to bit 0 and sign- or
// zero-extends the result to the full data width.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]                i_word,
  input  logic [$clog2(DATA_W/LANE_W)-1:0] i_off,
  input  mem_size_e                        i_size,
  input  logic                             i_unsigned,
  output logic [DATA_W-1:0]                o_data
);

  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_mask;
  logic              w_msb;
  logic              w_ext;

  assign w_shift = i_word >> {i_off, 3'b000};

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    w_mask = '1;
    w_msb  = w_shift[DATA_W-1];
    case (i_size)
      SZ_BYTE: begin w_mask = DATA_W'(8'hFF);        w_msb = w_shift[7];  end
      SZ_HALF: begin w_mask = DATA_W'(16'hFFFF);     w_msb = w_shift[15]; end
      SZ_WORD: begin w_mask = DATA_W'(32'hFFFF_FFFF); w_msb = w_shift[31]; end
      default: ;
    endcase
    w_ext  = ~i_unsigned & w_msb;
    o_data = (w_shift & w_mask) | (w_ext ? ~w_mask : '0);
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Byte-addressable data memory with a one-cycle load pipe and a power-up clear.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module data_mem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [DATA_W-1:0] data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  output logic [DATA_W-1:0] MemOut,
  output logic              MemValid,
  output logic              MemErr,
  output logic              Busy
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int OFF_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_e       r_state;
  dmem_state_e       w_state_nxt;
  logic [IDX_W-1:0]  r_clr_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_out;
  logic              r_valid;
  logic              r_err;

  mem_size_e         w_size;
  logic [OFF_W-1:0]  w_off_raw;
  logic [OFF_W-1:0]  w_size_mask;
  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_ready;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_bad;
  logic              w_load;
  logic              w_store;
  logic              w_err;
  logic [LANES-1:0]  w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_load_data;
  logic              w_unused_addr;

  // Upper address bits wrap around the array and are deliberately ignored.
  assign w_unused_addr = ^data_address;

  assign w_size      = mem_size_e'(MemSize);
  assign w_off_raw   = data_address[OFF_W-1:0];
  assign w_idx       = data_address[IDX_W+OFF_W-1:OFF_W];
  assign w_size_mask = OFF_W'(size_mask(w_size));
  assign w_off       = w_off_raw & ~w_size_mask;
  assign w_illegal   = (w_size == SZ_DWORD) && (DATA_W == 32);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = |(w_off_raw & w_size_mask);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_ready = (r_state == ST_READY);
  assign w_bad   = w_illegal | w_misalign;
  assign w_load  = w_ready & MemRead  & ~w_bad;
  assign w_store = w_ready & MemWrite & ~w_bad;
  assign w_err   = w_ready & (MemRead | MemWrite) & w_bad;

  assign w_be    = LANES'(size_lanes(w_size)) << w_off;
  assign w_wdata = data << {w_off, 3'b000};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_clr_idx <= r_clr_idx + IDX_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    Busy        = 1'b0;
    case (r_state)
      ST_INIT: begin
        Busy = 1'b1;
        if (r_clr_idx == IDX_W'(DEPTH - 1)) w_state_nxt = ST_READY;
      end
      default: ;
    endcase
  end

  // NOTE: the array has no reset; ST_INIT walks it and writes zero one word per cycle.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_store) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_be[i]) r_mem[w_idx][i*LANE_W +: LANE_W] <= w_wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Combinational read ahead of the edge gives read-first behaviour on a same-cycle store.
  assign w_rd_word = r_mem[w_idx];

  dmem_load_align #(.DATA_W(DATA_W)) u_load_align (
    .i_word     (w_rd_word),
    .i_off      (w_off),
    .i_size     (w_size),
    .i_unsigned (MemUnsigned),
    .o_data     (w_load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_out   <= w_load ? w_load_data : '0;
      r_valid <= w_load;
      r_err   <= w_err;
    end
  end

  assign MemOut   = r_out;
  assign MemValid = r_valid;
  assign MemErr   = r_err;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe (DATA_W=32, DEPTH=1024) with hand-computed
// little-endian expectations; adapts the misalign case to DMEM_MISALIGN_TRAP_EN.
module tb_data_mem_pipe;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] data_address;
  logic [DATA_W-1:0] data;
  logic              MemRead;
  logic              MemWrite;
  logic [1:0]        MemSize;
  logic              MemUnsigned;
  logic [DATA_W-1:0] MemOut;
  logic              MemValid;
  logic              MemErr;
  logic              Busy;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_address (data_address),
    .data         (data),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemSize      (MemSize),
    .MemUnsigned  (MemUnsigned),
    .MemOut       (MemOut),
    .MemValid     (MemValid),
    .MemErr       (MemErr),
    .Busy         (Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one request for a single cycle; outputs are then sampled 1 time unit after the edge.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    MemRead      = rd;
    MemWrite     = wr;
    data_address = addr;
    data         = wdata;
    MemSize      = size;
    MemUnsigned  = uns;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] exp);
    access(1'b1, 1'b0, addr, 32'h0, size, uns);
    check({tag, "_valid"}, MemValid, 1'b1);
    check({tag, "_data"}, MemOut, exp);
  endtask

  // Count edges until Busy drops, bounded; also count any strobes seen while clearing.
  task automatic wait_init(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (Busy === 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      if (MemValid !== 1'b0 || MemErr !== 1'b0) bad++;
    end
  endtask

  int n_cyc;
  int n_bad;

  initial begin
    reset        = 1'b1;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    data_address = '0;
    data         = '0;
    MemSize      = 2'b10;
    MemUnsigned  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  Busy,     1'b1);
    check("rst_valid", MemValid, 1'b0);
    check("rst_err",   MemErr,   1'b0);
    check("rst_out",   MemOut,   32'h0);

    reset = 1'b0;
    wait_init(n_cyc, n_bad);
    check("init_cycles", n_cyc, DEPTH);
    check("init_quiet",  n_bad, 0);

    do_load("lw_0", 32'h0, 2'b10, 1'b0, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("idle_valid", MemValid, 1'b0);
    check("idle_out",   MemOut,   32'h0);

    // Lanes at 0x10..0x13: 01 7F FF 80
    access(1'b0, 1'b1, 32'h10, 32'h80FF_7F01, 2'b10, 1'b0);
    check("sw_err", MemErr, 1'b0);
    do_load("lb_11_s",  32'h11, 2'b00, 1'b0, 32'h0000_007F);
    do_load("lbu_12",   32'h12, 2'b00, 1'b1, 32'h0000_00FF);
    do_load("lh_12_s",  32'h12, 2'b01, 1'b0, 32'hFFFF_80FF);
    do_load("lb_13_s",  32'h13, 2'b00, 1'b0, 32'hFFFF_FF80);
    do_load("lhu_12",   32'h12, 2'b01, 1'b1, 32'h0000_80FF);

    access(1'b0, 1'b1, 32'h13, 32'h0000_00AA, 2'b00, 1'b0);
    do_load("lw_after_sb", 32'h10, 2'b10, 1'b0, 32'hAAFF_7F01);
    do_load("lw_wrap",     32'h1010, 2'b10, 1'b0, 32'hAAFF_7F01);

    access(1'b1, 1'b1, 32'h20, 32'h1234_5678, 2'b10, 1'b0);
    check("rw_same_valid", MemValid, 1'b1);
    check("rw_same_old",   MemOut,   32'h0);
    do_load("rw_same_new", 32'h20, 2'b10, 1'b0, 32'h1234_5678);

    access(1'b0, 1'b1, 32'h21, 32'h0000_BEEF, 2'b01, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misal_err", MemErr, 1'b1);
    do_load("misal_mem", 32'h20, 2'b10, 1'b0, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h22, 32'h0, 2'b10, 1'b0);
    check("misal_ld_err",   MemErr,   1'b1);
    check("misal_ld_valid", MemValid, 1'b0);
    check("misal_ld_out",   MemOut,   32'h0);
`else
    check("misal_err", MemErr, 1'b0);
    do_load("misal_mem", 32'h20, 2'b10, 1'b0, 32'h1234_BEEF);
`endif

    access(1'b0, 1'b1, 32'h30, 32'hDEAD_BEEF, 2'b11, 1'b0);
    check("dw_st_err", MemErr, 1'b1);
    do_load("dw_st_mem", 32'h30, 2'b10, 1'b0, 32'h0);
    access(1'b1, 1'b0, 32'h30, 32'h0, 2'b11, 1'b0);
    check("dw_ld_err",   MemErr,   1'b1);
    check("dw_ld_valid", MemValid, 1'b0);
    check("dw_ld_out",   MemOut,   32'h0);

    access(1'b0, 1'b1, 32'h42, 32'h0000_8001, 2'b01, 1'b0);
    do_load("lhu_42", 32'h42, 2'b01, 1'b1, 32'h0000_8001);
    do_load("lh_42",  32'h42, 2'b01, 1'b0, 32'hFFFF_8001);
    do_load("lw_40",  32'h40, 2'b10, 1'b0, 32'h8001_0000);

    // Reset lands while a load result is being presented.
    do_load("pre_abort", 32'h10, 2'b10, 1'b0, 32'hAAFF_7F01);
    reset = 1'b1;
    #1;
    check("abort_valid", MemValid, 1'b0);
    check("abort_out",   MemOut,   32'h0);
    check("abort_busy",  Busy,     1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    repeat (500) @(posedge clk);
    #1;
    check("mid_busy", Busy, 1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset        = 1'b0;
    MemRead      = 1'b1;
    MemWrite     = 1'b1;
    data_address = 32'h44;
    data         = 32'hFFFF_FFFF;
    MemSize      = 2'b10;
    wait_init(n_cyc, n_bad);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    check("restart_cycles", n_cyc, DEPTH);
    check("restart_quiet",  n_bad, 0);
    do_load("init_write_ignored", 32'h44, 2'b10, 1'b0, 32'h0);
    do_load("cleared_10",         32'h10, 2'b10, 1'b0, 32'h0);
    do_load("cleared_40",         32'h40, 2'b10, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
